// File: rtl/regfile_pkg.sv
// Shared constants for the register-file access controller: geometry, FSM encoding, requester ids.
package regfile_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 16;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Bundle of pipeline/debug request lines and register-file row controls around the access controller.
interface regfile_access_ctrl_if;
  import regfile_pkg::*;

  logic            clr_start;
  logic            clr_busy;

  logic            a_wr_req;
  logic [AW-1:0]   a_wr_addr;
  logic [DW-1:0]   a_wr_data;
  logic            a_wr_gnt;

  logic            b_wr_req;
  logic [AW-1:0]   b_wr_addr;
  logic [DW-1:0]   b_wr_data;
  logic            b_wr_gnt;

  logic            a_rd1_en;
  logic [AW-1:0]   a_rd1_addr;
  logic            a_rd2_en;
  logic [AW-1:0]   a_rd2_addr;

  logic            b_rd_req;
  logic [AW-1:0]   b_rd_addr;
  logic            b_rd_gnt;
  logic            b_rd_valid;
  logic [DW-1:0]   b_rd_data;

  logic [NREG-1:0] rf_wen;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] rf_ren1;
  logic [NREG-1:0] rf_ren2;
  logic [DW-1:0]   rf_bl2;

  // Environment side: pipeline, debug master and the register-file array.
  modport master (
    output clr_start,
    output a_wr_req, a_wr_addr, a_wr_data,
    output b_wr_req, b_wr_addr, b_wr_data,
    output a_rd1_en, a_rd1_addr, a_rd2_en, a_rd2_addr,
    output b_rd_req, b_rd_addr,
    output rf_bl2,
    input  clr_busy, a_wr_gnt, b_wr_gnt, b_rd_gnt, b_rd_valid, b_rd_data,
    input  rf_wen, rf_wdata, rf_ren1, rf_ren2
  );

  // Controller side.
  modport slave (
    input  clr_start,
    input  a_wr_req, a_wr_addr, a_wr_data,
    input  b_wr_req, b_wr_addr, b_wr_data,
    input  a_rd1_en, a_rd1_addr, a_rd2_en, a_rd2_addr,
    input  b_rd_req, b_rd_addr,
    input  rf_bl2,
    output clr_busy, a_wr_gnt, b_wr_gnt, b_rd_gnt, b_rd_valid, b_rd_data,
    output rf_wen, rf_wdata, rf_ren1, rf_ren2
  );

endinterface

// File: rtl/regfile_access_ctrl_reg_decoder.sv
// Register address to one-hot row select, all zero when disabled.
module reg_decoder
  import regfile_pkg::*;
(
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [NREG-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      sel[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: write-port arbitration (A/B round robin), read port 2 lending
// to B, and a clear sequencer that zeroes R1..R15.
module regfile_access_ctrl
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  regfile_access_ctrl_if.slave bus
);

  logic [0:0]    state, state_n;
  logic [AW-1:0] clr_cnt, clr_cnt_n;
  logic          rr_last, rr_last_n;
  logic          b_rd_valid_q;
  logic [DW-1:0] b_rd_data_q;

  logic          a_gnt, b_gnt, rd_gnt;
  logic          wen_en;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          idle;

  assign idle   = (state == IDLE);
  assign rd_gnt = bus.b_rd_req && !bus.a_rd2_en && idle;

  // State register and registered B read return.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      clr_cnt      <= AW'(1);
      rr_last      <= REQ_B;
      b_rd_valid_q <= 1'b0;
      b_rd_data_q  <= '0;
    end else begin
      state        <= state_n;
      clr_cnt      <= clr_cnt_n;
      rr_last      <= rr_last_n;
      b_rd_valid_q <= rd_gnt;
      if (rd_gnt) b_rd_data_q <= bus.rf_bl2;
    end
  end

  // Next state, write arbitration and write-port mux.
  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    rr_last_n = rr_last;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    wen_en    = 1'b0;
    waddr     = '0;
    wdata     = '0;

    case (state)
      IDLE: begin
        if (bus.clr_start) state_n = CLEAR;
        // On a tie the requester that did not win last time goes first.
        if (bus.a_wr_req && (!bus.b_wr_req || rr_last == REQ_B)) begin
          a_gnt     = 1'b1;
          rr_last_n = REQ_A;
          waddr     = bus.a_wr_addr;
          wdata     = bus.a_wr_data;
          wen_en    = (bus.a_wr_addr != '0);
        end else if (bus.b_wr_req) begin
          b_gnt     = 1'b1;
          rr_last_n = REQ_B;
          waddr     = bus.b_wr_addr;
          wdata     = bus.b_wr_data;
          wen_en    = (bus.b_wr_addr != '0);
        end
      end
      CLEAR: begin
        wen_en = 1'b1;
        waddr  = clr_cnt;
        if (clr_cnt == AW'(NREG - 1)) begin
          state_n   = IDLE;
          clr_cnt_n = AW'(1);
        end else begin
          clr_cnt_n = clr_cnt + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  reg_decoder u_dec_w (
    .en   (wen_en),
    .addr (waddr),
    .sel  (bus.rf_wen)
  );

  reg_decoder u_dec_r1 (
    .en   (bus.a_rd1_en),
    .addr (bus.a_rd1_addr),
    .sel  (bus.rf_ren1)
  );

  // Port 2 belongs to A whenever it wants it; B only gets it through rd_gnt.
  reg_decoder u_dec_r2 (
    .en   (bus.a_rd2_en || rd_gnt),
    .addr (bus.a_rd2_en ? bus.a_rd2_addr : bus.b_rd_addr),
    .sel  (bus.rf_ren2)
  );

  assign bus.clr_busy   = (state == CLEAR);
  assign bus.a_wr_gnt   = a_gnt;
  assign bus.b_wr_gnt   = b_gnt;
  assign bus.b_rd_gnt   = rd_gnt;
  assign bus.b_rd_valid = b_rd_valid_q;
  assign bus.b_rd_data  = b_rd_data_q;
  assign bus.rf_wdata   = wdata;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl: reset, arbitration, clear sequence, read lending, R0, reset abort.
module tb_regfile_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  regfile_access_ctrl_if bus ();

  regfile_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.clr_start  = 1'b0;
    bus.a_wr_req   = 1'b0;  bus.a_wr_addr = '0;  bus.a_wr_data = '0;
    bus.b_wr_req   = 1'b0;  bus.b_wr_addr = '0;  bus.b_wr_data = '0;
    bus.a_rd1_en   = 1'b0;  bus.a_rd1_addr = '0;
    bus.a_rd2_en   = 1'b0;  bus.a_rd2_addr = '0;
    bus.b_rd_req   = 1'b0;  bus.b_rd_addr = '0;
    bus.rf_bl2     = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL reset_clr_busy: got %b want 0", bus.clr_busy); end
    checks++; if (bus.b_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_b_rd_valid: got %b want 0", bus.b_rd_valid); end
    checks++; if (bus.b_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_b_rd_data: got %h want 0000", bus.b_rd_data); end
    checks++; if (bus.rf_wen !== 16'h0000) begin errors++; $display("FAIL reset_rf_wen: got %h want 0000", bus.rf_wen); end
    checks++; if (bus.rf_ren2 !== 16'h0000) begin errors++; $display("FAIL reset_rf_ren2: got %h want 0000", bus.rf_ren2); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.rf_wdata !== 16'h0000) begin errors++; $display("FAIL idle_rf_wdata: got %h want 0000", bus.rf_wdata); end
  endtask

  task automatic test_a_write();
    @(negedge clk);
    bus.a_wr_req = 1'b1; bus.a_wr_addr = 4'd5; bus.a_wr_data = 16'hBEEF;
    #1;
    checks++; if (bus.a_wr_gnt !== 1'b1) begin errors++; $display("FAIL a_write_gnt: got %b want 1", bus.a_wr_gnt); end
    checks++; if (bus.b_wr_gnt !== 1'b0) begin errors++; $display("FAIL a_write_bgnt: got %b want 0", bus.b_wr_gnt); end
    checks++; if (bus.rf_wen !== 16'h0020) begin errors++; $display("FAIL a_write_wen: got %h want 0020", bus.rf_wen); end
    checks++; if (bus.rf_wdata !== 16'hBEEF) begin errors++; $display("FAIL a_write_wdata: got %h want beef", bus.rf_wdata); end
    @(negedge clk);
    bus.a_wr_req = 1'b0;
  endtask

  task automatic test_round_robin();
    logic exp_a;
    do_reset();
    @(negedge clk);
    bus.a_wr_req = 1'b1; bus.a_wr_addr = 4'd2; bus.a_wr_data = 16'h1111;
    bus.b_wr_req = 1'b1; bus.b_wr_addr = 4'd4; bus.b_wr_data = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++; if (bus.a_wr_gnt !== exp_a) begin errors++; $display("FAIL rr_a_gnt[%0d]: got %b want %b", i, bus.a_wr_gnt, exp_a); end
      checks++; if (bus.b_wr_gnt !== !exp_a) begin errors++; $display("FAIL rr_b_gnt[%0d]: got %b want %b", i, bus.b_wr_gnt, !exp_a); end
      checks++; if (bus.rf_wen !== (exp_a ? 16'h0004 : 16'h0010)) begin errors++; $display("FAIL rr_wen[%0d]: got %h", i, bus.rf_wen); end
      checks++; if (bus.rf_wdata !== (exp_a ? 16'h1111 : 16'h2222)) begin errors++; $display("FAIL rr_wdata[%0d]: got %h", i, bus.rf_wdata); end
      @(negedge clk);
    end
    bus.a_wr_req = 1'b0;
    #1;
    checks++; if (bus.b_wr_gnt !== 1'b1) begin errors++; $display("FAIL b_alone_gnt: got %b want 1", bus.b_wr_gnt); end
    @(negedge clk);
    bus.b_wr_req = 1'b0;
    #1;
    checks++; if (bus.rf_wen !== 16'h0000) begin errors++; $display("FAIL no_req_wen: got %h want 0000", bus.rf_wen); end
  endtask

  task automatic test_clear();
    logic [15:0] exp_wen;
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    bus.a_wr_req = 1'b1; bus.a_wr_addr = 4'd7; bus.a_wr_data = 16'h7777;
    bus.a_rd1_en = 1'b1; bus.a_rd1_addr = 4'd9;
    for (int i = 1; i <= 15; i++) begin
      bus.clr_start = (i == 8);
      exp_wen = 16'h0001 << i;
      #1;
      checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL clr_busy[%0d]: got %b want 1", i, bus.clr_busy); end
      checks++; if (bus.rf_wen !== exp_wen) begin errors++; $display("FAIL clr_wen[%0d]: got %h want %h", i, bus.rf_wen, exp_wen); end
      checks++; if (bus.rf_wdata !== 16'h0000) begin errors++; $display("FAIL clr_wdata[%0d]: got %h want 0000", i, bus.rf_wdata); end
      checks++; if (bus.a_wr_gnt !== 1'b0) begin errors++; $display("FAIL clr_a_gnt[%0d]: got %b want 0", i, bus.a_wr_gnt); end
      checks++; if (bus.rf_ren1 !== 16'h0200) begin errors++; $display("FAIL clr_ren1[%0d]: got %h want 0200", i, bus.rf_ren1); end
      @(negedge clk);
    end
    bus.clr_start = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got %b want 0", bus.clr_busy); end
    checks++; if (bus.a_wr_gnt !== 1'b1) begin errors++; $display("FAIL clr_done_a_gnt: got %b want 1", bus.a_wr_gnt); end
    checks++; if (bus.rf_wen !== 16'h0080) begin errors++; $display("FAIL clr_done_wen: got %h want 0080", bus.rf_wen); end
    @(negedge clk);
    bus.a_wr_req = 1'b0; bus.a_rd1_en = 1'b0;
  endtask

  task automatic test_b_read();
    @(negedge clk);
    bus.b_rd_req = 1'b1; bus.b_rd_addr = 4'd3;
    bus.a_rd2_en = 1'b1; bus.a_rd2_addr = 4'd6;
    bus.rf_bl2 = 16'hCAFE;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.b_rd_gnt !== 1'b0) begin errors++; $display("FAIL rd_blocked_gnt[%0d]: got %b want 0", i, bus.b_rd_gnt); end
      checks++; if (bus.rf_ren2 !== 16'h0040) begin errors++; $display("FAIL rd_blocked_ren2[%0d]: got %h want 0040", i, bus.rf_ren2); end
      checks++; if (bus.b_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_blocked_valid[%0d]: got %b want 0", i, bus.b_rd_valid); end
      @(negedge clk);
    end
    bus.a_rd2_en = 1'b0;
    #1;
    checks++; if (bus.b_rd_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", bus.b_rd_gnt); end
    checks++; if (bus.rf_ren2 !== 16'h0008) begin errors++; $display("FAIL rd_ren2: got %h want 0008", bus.rf_ren2); end
    @(posedge clk);
    #1;
    checks++; if (bus.b_rd_valid !== 1'b1) begin errors++; $display("FAIL rd_valid: got %b want 1", bus.b_rd_valid); end
    checks++; if (bus.b_rd_data !== 16'hCAFE) begin errors++; $display("FAIL rd_data: got %h want cafe", bus.b_rd_data); end
    @(negedge clk);
    bus.b_rd_req = 1'b0; bus.rf_bl2 = 16'h0000;
    @(posedge clk);
    #1;
    checks++; if (bus.b_rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", bus.b_rd_valid); end
    checks++; if (bus.b_rd_data !== 16'hCAFE) begin errors++; $display("FAIL rd_data_hold: got %h want cafe", bus.b_rd_data); end
  endtask

  task automatic test_b_write_r0();
    @(negedge clk);
    bus.b_wr_req = 1'b1; bus.b_wr_addr = 4'd0; bus.b_wr_data = 16'h1234;
    #1;
    checks++; if (bus.b_wr_gnt !== 1'b1) begin errors++; $display("FAIL r0_gnt: got %b want 1", bus.b_wr_gnt); end
    checks++; if (bus.rf_wen !== 16'h0000) begin errors++; $display("FAIL r0_wen: got %h want 0000", bus.rf_wen); end
    @(negedge clk);
    bus.b_wr_req = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    @(negedge clk);
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (bus.rf_wen !== 16'h0080) begin errors++; $display("FAIL abort_pre_wen: got %h want 0080", bus.rf_wen); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.clr_busy); end
    checks++; if (bus.rf_wen !== 16'h0000) begin errors++; $display("FAIL abort_wen: got %h want 0000", bus.rf_wen); end
    @(negedge clk);
    rst = 1'b1;
    bus.clr_start = 1'b1;
    @(negedge clk);
    bus.clr_start = 1'b0;
    #1;
    checks++; if (bus.clr_busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %b want 1", bus.clr_busy); end
    checks++; if (bus.rf_wen !== 16'h0002) begin errors++; $display("FAIL restart_wen: got %h want 0002", bus.rf_wen); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_a_write();
    test_round_robin();
    test_clear();
    test_b_read();
    test_b_write_r0();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
